// File: rtl/wb_sdram_pkg.sv
// Shared definitions for the Wishbone burst reader.
// Provides Wishbone cycle-type / burst-type codes and the reader FSM
// state encoding. No ports.
package wb_sdram_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_BURST      = 2'd2,
    ST_NEXT       = 2'd3
  } state_t;

endpackage

// File: rtl/wb_burst_reader_if.sv
// Bundle of the burst reader's command, stream and Wishbone signals.
// Modports:
//   master - the burst reader (drives Wishbone request and stream outputs)
//   slave  - the environment (command source, stream sink, Wishbone responder)
interface wb_burst_reader_if #(
  parameter int LEN_WIDTH = 16
);
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [31:0]          cmd_adr_i;
  logic [LEN_WIDTH-1:0] cmd_len_i;
  logic                 busy_o;
  logic                 done_o;

  logic [31:0]          dat_o;
  logic                 valid_o;
  logic                 ready_i;

  logic [31:0]          wb_adr_o;
  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic [2:0]           wb_cti_o;
  logic [1:0]           wb_bte_o;
  logic                 wb_we_o;
  logic [3:0]           wb_sel_o;
  logic [31:0]          wb_dat_i;
  logic                 wb_ack_i;

  modport master (
    input  cmd_valid_i, cmd_adr_i, cmd_len_i, ready_i, wb_dat_i, wb_ack_i,
    output cmd_ready_o, busy_o, done_o, dat_o, valid_o,
           wb_adr_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o, wb_we_o, wb_sel_o
  );

  modport slave (
    output cmd_valid_i, cmd_adr_i, cmd_len_i, ready_i, wb_dat_i, wb_ack_i,
    input  cmd_ready_o, busy_o, done_o, dat_o, valid_o,
           wb_adr_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o, wb_we_o, wb_sel_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered show-ahead output stage.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en, din      push
//   rd_en           pop request (consumer ready); pops when valid is high
//   dout, valid     registered head word and its valid flag
//   count           words held, including the output register
// A push into an empty FIFO bypasses the array straight into dout, so a
// written word is visible on the next cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      mem_cnt;

  logic pop, load, mem_empty, mem_rd, bypass, mem_wr;

  assign pop       = valid & rd_en;
  assign load      = ~valid | pop;
  assign mem_empty = (mem_cnt == '0);
  assign mem_rd    = load & ~mem_empty;
  assign bypass    = load & mem_empty & wr_en;
  assign mem_wr    = wr_en & ~bypass;
  assign count     = mem_cnt + (AW+1)'(valid);

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      dout    <= '0;
      valid   <= 1'b0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + AW'(1);
      if (mem_rd) rd_ptr <= rd_ptr + AW'(1);
      if (mem_wr && !mem_rd)      mem_cnt <= mem_cnt + (AW+1)'(1);
      else if (!mem_wr && mem_rd) mem_cnt <= mem_cnt - (AW+1)'(1);
      if (mem_rd) begin
        dout  <= mem[rd_ptr];
        valid <= 1'b1;
      end else if (bypass) begin
        dout  <= din;
        valid <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone B3 incrementing-burst read initiator feeding a valid/ready stream.
// Ports:
//   wb_clk, wb_rst_n  clock, asynchronous active-low reset
//   bus               wb_burst_reader_if.master: command (cmd_*, busy_o,
//                     done_o), stream (dat_o, valid_o, ready_i) and
//                     Wishbone master signals (wb_*)
//
// state         | meaning
// --------------+---------------------------------------------------------
// ST_IDLE       | accepting a command; zero-length commands finish here
// ST_WAIT_SPACE | waiting until the FIFO can absorb the whole next burst
// ST_BURST      | cyc/stb asserted, one FIFO push per ack
// ST_NEXT       | cyc low for a cycle; finish or start another burst
module wb_burst_reader
  import wb_sdram_pkg::*;
#(
  parameter int BURST_LENGTH = 8,
  parameter int FIFO_AW      = 4,
  parameter int LEN_WIDTH    = 16
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  wb_burst_reader_if.master bus
);

  localparam int OFS_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam int BL_W  = $clog2(BURST_LENGTH) + 1;
  localparam logic [FIFO_AW:0] FIFO_DEPTH = (FIFO_AW+1)'(1 << FIFO_AW);

  state_t               state_q, state_d;
  logic [29:0]          adr_q, adr_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [BL_W-1:0]      beats_left_q, beats_left_d;
  logic                 cyc_q, cyc_d;
  logic [2:0]           cti_q, cti_d;
  logic                 done_q, done_d;
  logic                 fifo_wr;
  logic [FIFO_AW:0]     fifo_count, fifo_free;

  logic [OFS_W-1:0]     ofs;
  logic [BL_W-1:0]      room, beat_cnt;
  logic                 space_ok;
  logic                 unused_adr_bits;

  assign unused_adr_bits = ^bus.cmd_adr_i[1:0];

  // Words left before the next BURST_LENGTH-aligned boundary; bursts are
  // clipped there so they never straddle an SDRAM burst.
  assign ofs      = (BURST_LENGTH > 1) ? adr_q[OFS_W-1:0] : '0;
  assign room     = BL_W'(BURST_LENGTH) - BL_W'(ofs);
  assign beat_cnt = (remaining_q < LEN_WIDTH'(room)) ? remaining_q[BL_W-1:0] : room;

  // Space is reserved for the whole burst up front, so the FIFO can never
  // overflow while acks are arriving.
  assign fifo_free = FIFO_DEPTH - fifo_count;
  assign space_ok  = 32'(fifo_free) >= 32'(beat_cnt);

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    remaining_d  = remaining_q;
    beats_left_d = beats_left_q;
    cyc_d        = cyc_q;
    cti_d        = cti_q;
    done_d       = 1'b0;
    fifo_wr      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          adr_d       = bus.cmd_adr_i[31:2];
          remaining_d = bus.cmd_len_i;
          if (bus.cmd_len_i == '0) done_d  = 1'b1;
          else                     state_d = ST_WAIT_SPACE;
        end
      end
      ST_WAIT_SPACE: begin
        if (space_ok) begin
          beats_left_d = beat_cnt;
          cyc_d        = 1'b1;
          cti_d        = (beat_cnt == BL_W'(1)) ? CTI_EOB : CTI_INC;
          state_d      = ST_BURST;
        end
      end
      ST_BURST: begin
        if (bus.wb_ack_i) begin
          fifo_wr      = 1'b1;
          adr_d        = adr_q + 30'd1;
          beats_left_d = beats_left_q - BL_W'(1);
          remaining_d  = remaining_q - LEN_WIDTH'(1);
          if (beats_left_q == BL_W'(1)) begin
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
            state_d = ST_NEXT;
          end else if (beats_left_q == BL_W'(2)) begin
            cti_d = CTI_EOB;
          end
        end
      end
      ST_NEXT: begin
        if (remaining_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_SPACE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q      <= ST_IDLE;
      adr_q        <= '0;
      remaining_q  <= '0;
      beats_left_q <= '0;
      cyc_q        <= 1'b0;
      cti_q        <= CTI_CLASSIC;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      remaining_q  <= remaining_d;
      beats_left_q <= beats_left_d;
      cyc_q        <= cyc_d;
      cti_q        <= cti_d;
      done_q       <= done_d;
    end
  end

  assign bus.cmd_ready_o = (state_q == ST_IDLE);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.done_o      = done_q;
  assign bus.wb_adr_o    = {adr_q, 2'b00};
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = cyc_q;
  assign bus.wb_cti_o    = cti_q;
  assign bus.wb_bte_o    = BTE_LINEAR;
  assign bus.wb_we_o     = 1'b0;
  assign bus.wb_sel_o    = 4'hF;

  sync_fifo #(
    .WIDTH (32),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (wb_clk),
    .rst_n (wb_rst_n),
    .wr_en (fifo_wr),
    .din   (bus.wb_dat_i),
    .rd_en (bus.ready_i),
    .dout  (bus.dat_o),
    .valid (bus.valid_o),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_wb_burst_reader.sv
module tb_wb_burst_reader;
  import wb_sdram_pkg::*;

  localparam int TB_BL = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_burst_reader_if #(.LEN_WIDTH(16)) bus ();

  wb_burst_reader #(
    .BURST_LENGTH (TB_BL),
    .FIFO_AW      (4),
    .LEN_WIDTH    (16)
  ) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .bus      (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int ack_cnt     = 0;
  int done_cnt    = 0;
  bit rand_stall  = 1'b0;
  bit eob_seen    = 1'b0;

  logic [31:0] exp_adr_q  [$];
  logic [2:0]  exp_cti_q  [$];
  logic [31:0] exp_data_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference segmentation: bursts clipped at TB_BL-word boundaries.
  task automatic push_expect(input logic [31:0] adr, input int len);
    logic [31:0] a;
    int left;
    a = {adr[31:2], 2'b00};
    left = 0;
    for (int i = 0; i < len; i++) begin
      if (left == 0) begin
        int room;
        room = TB_BL - int'((a >> 2) % 32'(TB_BL));
        left = (len - i < room) ? (len - i) : room;
      end
      exp_adr_q.push_back(a);
      exp_cti_q.push_back((left == 1) ? CTI_EOB : CTI_INC);
      exp_data_q.push_back(mem_word(a));
      left--;
      a = a + 32'd4;
    end
  endtask

  task automatic send_cmd(input logic [31:0] adr, input int len);
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_adr_i   = adr;
    bus.cmd_len_i   = 16'(len);
    @(negedge clk);
    chk("cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    n = 0;
    while ((bus.busy_o || exp_data_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finish_in_time"}, {31'd0, n < budget}, 32'd1);
    @(negedge clk);
  endtask

  task automatic run_req(input logic [31:0] adr, input int len, input string tag);
    int d0, a0;
    d0 = done_cnt;
    a0 = ack_cnt;
    push_expect(adr, len);
    send_cmd(adr, len);
    wait_quiet(tag, 3000);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_beats"}, 32'(ack_cnt - a0), 32'(len));
    chk({tag, "_adr_q_empty"}, 32'(exp_adr_q.size()), 32'd0);
  endtask

  // Wishbone responder and bus-side checker.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      bus.wb_ack_i = 1'b0;
      eob_seen     = 1'b0;
    end else begin
      if (eob_seen) begin
        chk("cyc_low_after_eob", {31'd0, bus.wb_cyc_o}, 32'd0);
        eob_seen = 1'b0;
      end
      if (bus.wb_cyc_o && bus.wb_stb_o && (!rand_stall || $urandom_range(0, 2) == 0)) begin
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = mem_word(bus.wb_adr_o);
        ack_cnt++;
        chk("beat_expected", {31'd0, exp_adr_q.size() != 0}, 32'd1);
        if (exp_adr_q.size() != 0) begin
          chk("wb_adr", bus.wb_adr_o, exp_adr_q.pop_front());
          chk("wb_cti", {29'd0, bus.wb_cti_o}, {29'd0, exp_cti_q.pop_front()});
        end
        if (bus.wb_cti_o == CTI_EOB) eob_seen = 1'b1;
      end else begin
        bus.wb_ack_i = 1'b0;
      end
    end
  end

  // Stream scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.valid_o) begin
      chk("word_expected", {31'd0, exp_data_q.size() != 0}, 32'd1);
      if (exp_data_q.size() != 0) begin
        if (bus.ready_i) chk("stream_dat", bus.dat_o, exp_data_q.pop_front());
        else             chk("stream_hold", bus.dat_o, exp_data_q[0]);
      end
    end
    if (rst_n && bus.done_o) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, a0, n;
    rst_n           = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_len_i   = '0;
    bus.ready_i     = 1'b1;
    bus.wb_dat_i    = '0;
    bus.wb_ack_i    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    chk("rst_busy",      {31'd0, bus.busy_o},      32'd0);
    chk("rst_done",      {31'd0, bus.done_o},      32'd0);
    chk("rst_valid",     {31'd0, bus.valid_o},     32'd0);
    chk("rst_cyc",       {31'd0, bus.wb_cyc_o},    32'd0);
    chk("rst_stb",       {31'd0, bus.wb_stb_o},    32'd0);
    chk("rst_cti",       {29'd0, bus.wb_cti_o},    32'd0);
    chk("rst_adr",       bus.wb_adr_o,             32'd0);
    chk("rst_dat",       bus.dat_o,                32'd0);
    chk("const_bte",     {30'd0, bus.wb_bte_o},    32'd0);
    chk("const_we",      {31'd0, bus.wb_we_o},     32'd0);
    chk("const_sel",     {28'd0, bus.wb_sel_o},    32'hF);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_req(32'h0000_0100, 16, "aligned16");
    run_req(32'h0000_0114, 6, "unaligned6");

    // Zero length: done the cycle after acceptance, no bus cycle.
    d0 = done_cnt;
    a0 = ack_cnt;
    send_cmd(32'h0000_0040, 0);
    @(negedge clk);
    chk("zero_done_t1", {31'd0, bus.done_o},   32'd1);
    chk("zero_cyc",     {31'd0, bus.wb_cyc_o}, 32'd0);
    chk("zero_busy",    {31'd0, bus.busy_o},   32'd0);
    @(negedge clk);
    chk("zero_done_t2", {31'd0, bus.done_o},   32'd0);
    chk("zero_beats",   32'(ack_cnt - a0),     32'd0);

    // Single word: WAIT_SPACE at T+1, cyc at T+2 with cti=111.
    d0 = done_cnt;
    a0 = ack_cnt;
    push_expect(32'h0000_001C, 1);
    send_cmd(32'h0000_001C, 1);
    @(negedge clk);
    chk("single_cyc_t1",  {31'd0, bus.wb_cyc_o}, 32'd0);
    chk("single_busy_t1", {31'd0, bus.busy_o},   32'd1);
    @(negedge clk);
    chk("single_cyc_t2",  {31'd0, bus.wb_cyc_o}, 32'd1);
    chk("single_cti",     {29'd0, bus.wb_cti_o}, {29'd0, CTI_EOB});
    chk("single_adr",     bus.wb_adr_o,          32'h0000_001C);
    wait_quiet("single", 200);
    chk("single_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("single_beats",       32'(ack_cnt - a0),  32'd1);

    // Backpressure: FIFO fills to 16 words, then fetching stalls.
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    d0 = done_cnt;
    a0 = ack_cnt;
    push_expect(32'h0000_0400, 40);
    send_cmd(32'h0000_0400, 40);
    repeat (100) @(negedge clk);
    chk("bp_fetched", 32'(ack_cnt - a0),      32'd16);
    chk("bp_cyc",     {31'd0, bus.wb_cyc_o},  32'd0);
    chk("bp_busy",    {31'd0, bus.busy_o},    32'd1);
    chk("bp_valid",   {31'd0, bus.valid_o},   32'd1);
    @(posedge clk); #1;
    bus.ready_i = 1'b1;
    wait_quiet("bp", 3000);
    chk("bp_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("bp_beats",       32'(ack_cnt - a0),  32'd40);

    // Random ack stalls, address wrap across 2^32.
    rand_stall = 1'b1;
    run_req(32'hFFFF_FFF8, 4, "wrap");
    run_req(32'h0000_02A4, 20, "stall20");

    // Reset during beat 3 of a burst.
    rand_stall = 1'b0;
    push_expect(32'h0000_0200, 8);
    send_cmd(32'h0000_0200, 8);
    n = 0;
    while (!(bus.wb_cyc_o && bus.wb_adr_o == 32'h0000_0208) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_beat3", {31'd0, n < 200}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc",       {31'd0, bus.wb_cyc_o},    32'd0);
    chk("midrst_stb",       {31'd0, bus.wb_stb_o},    32'd0);
    chk("midrst_valid",     {31'd0, bus.valid_o},     32'd0);
    chk("midrst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    chk("midrst_adr",       bus.wb_adr_o,             32'd0);
    repeat (3) @(negedge clk);
    exp_adr_q.delete();
    exp_cti_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    chk("postrst_valid",     {31'd0, bus.valid_o},     32'd0);
    chk("postrst_busy",      {31'd0, bus.busy_o},      32'd0);
    chk("postrst_dat",       bus.dat_o,                32'd0);
    run_req(32'h0000_0300, 4, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
